tmr_count_unit: RTL and testbench

Timer count engine that produces the counter stream consumed by the overflow/underflow checker. It also terminates that checker's flag outputs into sticky status bits.
- 8-bit up/down counter with prescaler, load and enable.
- Publishes the current and previous counter values so wrap events can be detected downstream.
- Latches the checker's ovf/udf pulses into sticky status bits, returns clear requests, and generates the timer interrupt.

---
 rtl/tmr_count_unit.sv | 65 ++++++
 tb/tb_tmr_count_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tmr_count_unit.sv
// Timer count engine: prescaled 8-bit up/down counter feeding the overflow/underflow
// checker, plus sticky ovf/udf status, clear strobe return and timer interrupt.
module tmr_count_unit #(
  parameter int PRESC_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic             checkflow_clk,
  input  logic             checkflow_reset_n,
  input  logic             tcr_en,
  input  logic             tcr_load,
  input  logic             tcr_up_down,
  input  logic [1:0]       tcr_cks,
  input  logic [CNT_W-1:0] tdr,
  input  logic             ovf_pulse,
  input  logic             udf_pulse,
  input  logic [1:0]       tsr_clr,
  input  logic [1:0]       tier,
  output logic [CNT_W-1:0] counter_value,
  output logic [CNT_W-1:0] counter_last_value,
  output logic [1:0]       clear_flag,
  output logic             tsr_ovf,
  output logic             tsr_udf,
  output logic             tmr_int
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_mask;
  logic               run;
  logic               tick;

  // Low (tcr_cks+1) prescaler bits all ones marks the last clock of a period.
  always_comb begin
    presc_mask = '0;
    for (int i = 0; i < PRESC_W; i++)
      if (i <= int'(tcr_cks)) presc_mask[i] = 1'b1;
  end

  assign run  = tcr_en & ~tcr_load;
  assign tick = run & ((presc & presc_mask) == presc_mask);

  always_ff @(posedge checkflow_clk or negedge checkflow_reset_n) begin
    if (!checkflow_reset_n) begin
      presc              <= '0;
      counter_value      <= '0;
      counter_last_value <= '0;
      clear_flag         <= '0;
      tsr_ovf            <= 1'b0;
      tsr_udf            <= 1'b0;
    end else begin
      presc <= run ? presc + PRESC_W'(1) : '0;
      if (tcr_load)
        counter_value <= tdr;
      else if (tick)
        counter_value <= tcr_up_down ? counter_value - CNT_W'(1) : counter_value + CNT_W'(1);
      counter_last_value <= counter_value;
      clear_flag         <= tsr_clr;
      // A pulse in the same cycle as its clear keeps the flag set.
      tsr_ovf <= ovf_pulse | (tsr_ovf & ~tsr_clr[0]);
      tsr_udf <= udf_pulse | (tsr_udf & ~tsr_clr[1]);
    end
  end

  assign tmr_int = (tsr_ovf & tier[0]) | (tsr_udf & tier[1]);

endmodule

// File: tb/tb_tmr_count_unit.sv
// Bench for tmr_count_unit: directed scenarios plus random traffic, each cycle checked
// against an arithmetic model of the timer.
module tb_tmr_count_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, load = 1'b0, up_down = 1'b0;
  logic [1:0] cks = 2'b00;
  logic [7:0] tdr = 8'h00;
  logic       ovf_p = 1'b0, udf_p = 1'b0;
  logic [1:0] clr = 2'b00, tier = 2'b00;
  logic [7:0] cnt, last;
  logic [1:0] clear_flag;
  logic       ovf, udf, irq;

  int checks = 0, errors = 0;
  int m_cnt = 0, m_last = 0, m_edges = 0, m_clr = 0;
  bit m_ovf = 0, m_udf = 0;
  int wraps;

  tmr_count_unit dut (
    .checkflow_clk(clk), .checkflow_reset_n(rst_n),
    .tcr_en(en), .tcr_load(load), .tcr_up_down(up_down), .tcr_cks(cks), .tdr(tdr),
    .ovf_pulse(ovf_p), .udf_pulse(udf_p), .tsr_clr(clr), .tier(tier),
    .counter_value(cnt), .counter_last_value(last), .clear_flag(clear_flag),
    .tsr_ovf(ovf), .tsr_udf(udf), .tmr_int(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("counter_value", int'(cnt), m_cnt);
    chk("counter_last_value", int'(last), m_last);
    chk("clear_flag", int'(clear_flag), m_clr);
    chk("tsr_ovf", int'(ovf), int'(m_ovf));
    chk("tsr_udf", int'(udf), int'(m_udf));
    chk("tmr_int", int'(irq), int'((m_ovf & tier[0]) | (m_udf & tier[1])));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int  period;
    bit  tk;
    @(posedge clk);
    period = 1 << (int'(cks) + 1);
    // m_edges counts consecutive enabled, non-loading edges (prescaler wraps at 16).
    tk = en && !load && ((m_edges % period) == period - 1);
    m_last = m_cnt;
    if (load) m_cnt = int'(tdr);
    else if (tk) m_cnt = up_down ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
    m_edges = (en && !load) ? (m_edges + 1) % 16 : 0;
    m_ovf = ovf_p || (m_ovf && !clr[0]);
    m_udf = udf_p || (m_udf && !clr[1]);
    m_clr = int'(clr);
    #1;
    chk_all();
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = 0; m_edges = 0; m_clr = 0; m_ovf = 0; m_udf = 0;
  endtask

  initial begin
    #12;
    chk_all();
    chk("reset_counter", int'(cnt), 0);
    @(negedge clk) rst_n = 1'b1;

    // Up count, divide by 2
    en = 1'b1; cks = 2'b00; up_down = 1'b0;
    step();
    chk("first_tick_not_yet", int'(cnt), 0);
    step();
    chk("first_tick_div2", int'(cnt), 1);
    repeat (6) step();

    // Load FE, divide by 4, overflow wrap
    en = 1'b0; load = 1'b1; tdr = 8'hFE;
    step();
    load = 1'b0; en = 1'b1; cks = 2'b01;
    wraps = 0;
    repeat (9) begin
      step();
      if (last == 8'hFF && cnt == 8'h00) wraps++;
    end
    chk("ovf_wrap_cycles", wraps, 1);
    chk("after_ovf_wrap", int'(cnt), 0);
    ovf_p = 1'b1; tier = 2'b00;
    step();
    ovf_p = 1'b0;
    chk("ovf_sticky", int'(ovf), 1);
    chk("int_masked", int'(irq), 0);
    tier = 2'b01; #1;
    chk("int_enabled", int'(irq), 1);

    // Load 01, count down, divide by 16, underflow wrap
    en = 1'b0; load = 1'b1; tdr = 8'h01; up_down = 1'b1; cks = 2'b11;
    step();
    load = 1'b0; en = 1'b1;
    wraps = 0;
    repeat (33) begin
      step();
      if (last == 8'h00 && cnt == 8'hFF) wraps++;
    end
    chk("udf_wrap_cycles", wraps, 1);
    chk("after_udf_wrap", int'(cnt), 8'hFF);
    udf_p = 1'b1;
    step();
    udf_p = 1'b0;
    chk("udf_sticky", int'(udf), 1);

    // Set beats clear, then clear alone
    ovf_p = 1'b1; clr = 2'b01;
    step();
    chk("set_wins_clear", int'(ovf), 1);
    ovf_p = 1'b0; clr = 2'b01;
    step();
    clr = 2'b00;
    chk("ovf_cleared", int'(ovf), 0);
    chk("clear_flag_pulse", int'(clear_flag), 1);
    step();
    chk("clear_flag_drop", int'(clear_flag), 0);

    // Held load: counter pinned, prescaler held, full period after release
    up_down = 1'b0; cks = 2'b10; load = 1'b1; tdr = 8'h5A;
    repeat (10) step();
    chk("load_hold", int'(cnt), 8'h5A);
    load = 1'b0;
    repeat (7) step();
    chk("no_tick_before_8", int'(cnt), 8'h5A);
    step();
    chk("tick_after_8", int'(cnt), 8'h5B);

    // Async reset mid-count at 37 with ovf set
    load = 1'b1; tdr = 8'h37; ovf_p = 1'b1;
    step();
    load = 1'b0; ovf_p = 1'b0; cks = 2'b11;
    repeat (3) step();
    chk("pre_reset_cnt", int'(cnt), 8'h37);
    chk("pre_reset_ovf", int'(ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    chk("async_rst_cnt", int'(cnt), 0);
    chk("async_rst_int", int'(irq), 0);
    #3 rst_n = 1'b1;
    cks = 2'b00;
    step();
    step();
    chk("resume_after_reset", int'(cnt), 1);

    // Random traffic
    repeat (600) begin
      en      = ($urandom_range(3) != 0);
      load    = ($urandom_range(15) == 0);
      tdr     = 8'($urandom);
      if ($urandom_range(9) == 0) up_down = ~up_down;
      if ($urandom_range(19) == 0) cks = 2'($urandom);
      ovf_p   = ($urandom_range(7) == 0);
      udf_p   = ($urandom_range(7) == 0);
      clr     = {($urandom_range(7) == 0), ($urandom_range(7) == 0)};
      tier    = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
